// File: rtl/irq_req_latch_pkg.sv
// ============================================================================
// Module : irq_req_latch_pkg
// Brief  : Shared state encoding, default widths and width check helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package irq_req_latch_pkg;

  localparam int N_DEF    = 8;
  localparam int IDXW_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    BUSY  = 2'd2
  } state_t;

  function automatic bit width_ok(input int n, input int idxw);
    return idxw == $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/irq_edge_capture.sv
// ============================================================================
// Module : irq_edge_capture
// Brief  : Request edge/level capture into a pending register with clear and
//          sticky overflow detection.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module irq_edge_capture #(
  parameter int N    = 8,
  parameter int IDXW = 3,
  parameter int EDGE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    irq_in,
  input  logic            clr_en,
  input  logic [IDXW-1:0] clr_idx,
  output logic [N-1:0]    pending,
  output logic            overflow
);

  logic [N-1:0] irq_d;
  logic [N-1:0] rise;
  logic [N-1:0] set_vec;
  logic [N-1:0] clr_vec;

  assign rise = irq_in & ~irq_d;

  always_comb begin
    clr_vec = '0;
    if (clr_en) clr_vec[clr_idx] = 1'b1;
  end

  // Set is OR'd after the clear so a simultaneous new event survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_d   <= '0;
      pending <= '0;
    end else begin
      irq_d   <= irq_in;
      pending <= (pending & ~clr_vec) | set_vec;
    end
  end

  if (EDGE != 0) begin : g_edge
    assign set_vec = rise;

    always_ff @(posedge clk) begin
      if (rst)
        overflow <= 1'b0;
      else if (|(rise & pending & ~clr_vec))
        overflow <= 1'b1;
    end
  end else begin : g_level
    assign set_vec  = irq_in;
    assign overflow = 1'b0;
  end

endmodule

`default_nettype wire

// File: rtl/irq_req_latch.sv
// ============================================================================
// Module : irq_req_latch
// Brief  : Request capture, masked snapshot and valid/ready offer to the
//          priority encoder, with per-line clear on service completion.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module irq_req_latch
  import irq_req_latch_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int IDXW = IDXW_DEF,
  parameter int EDGE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    irq_in,
  input  logic [N-1:0]    irq_mask,
  output logic [N-1:0]    req_vec,
  output logic            req_valid,
  input  logic            req_ready,
  input  logic            done,
  input  logic [IDXW-1:0] done_idx,
  output logic [N-1:0]    pending,
  output logic            overflow
);

  localparam bit WIDTH_OK = width_ok(N, IDXW);

  if (!WIDTH_OK) begin : g_width_bad
    $error("irq_req_latch: IDXW must equal clog2(N)");
  end

  state_t       state;
  state_t       state_nxt;
  logic [N-1:0] vec_nxt;
  logic         clr_en;

  // Only a completion seen while servicing may retire a pending bit.
  assign clr_en = (state == BUSY) && done;

  irq_edge_capture #(
    .N    (N),
    .IDXW (IDXW),
    .EDGE (EDGE)
  ) u_capture (
    .clk      (clk),
    .rst      (rst),
    .irq_in   (irq_in),
    .clr_en   (clr_en),
    .clr_idx  (done_idx),
    .pending  (pending),
    .overflow (overflow)
  );

  always_comb begin
    state_nxt = state;
    vec_nxt   = req_vec;
    case (state)
      IDLE: begin
        if (|(pending & irq_mask)) begin
          state_nxt = OFFER;
          vec_nxt   = pending & irq_mask;
        end
      end
      OFFER: begin
        if (req_ready) state_nxt = BUSY;
      end
      BUSY: begin
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_vec   <= '0;
      req_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      req_vec   <= vec_nxt;
      req_valid <= (state_nxt == OFFER);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_irq_req_latch.sv
// ============================================================================
// Module : tb_irq_req_latch
// Brief  : Directed and randomized bench for irq_req_latch (N=8, EDGE=1).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_irq_req_latch;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_in;
  logic [7:0] irq_mask;
  logic [7:0] req_vec;
  logic       req_valid;
  logic       req_ready;
  logic       done;
  logic [2:0] done_idx;
  logic [7:0] pending;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  // Reference model: per-line pending flags, a snapshot and a service phase
  // (0 = waiting, 1 = offered, 2 = in service).
  logic [7:0] m_prev;
  logic [7:0] m_pend;
  logic [7:0] m_snap;
  bit         m_ovf;
  int         m_phase;

  always #5 clk = ~clk;

  irq_req_latch #(.N(8), .IDXW(3), .EDGE(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_in    (irq_in),
    .irq_mask  (irq_mask),
    .req_vec   (req_vec),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .done      (done),
    .done_idx  (done_idx),
    .pending   (pending),
    .overflow  (overflow)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [7:0] nxt;
    bit rose;
    bit served;
    if (rst) begin
      m_prev = '0; m_pend = '0; m_snap = '0; m_ovf = 1'b0; m_phase = 0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        rose   = irq_in[i] && !m_prev[i];
        served = (m_phase == 2) && done && (int'(done_idx) == i);
        if (rose && m_pend[i] && !served) m_ovf = 1'b1;
        nxt[i] = rose ? 1'b1 : (served ? 1'b0 : m_pend[i]);
      end
      case (m_phase)
        0: if ((m_pend & irq_mask) != 8'h00) begin
             m_snap  = m_pend & irq_mask;
             m_phase = 1;
           end
        1: if (req_ready) m_phase = 2;
        default: if (done) m_phase = 0;
      endcase
      m_prev = irq_in;
      m_pend = nxt;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("req_valid", {7'b0, req_valid}, {7'b0, (m_phase == 1)});
    chk("req_vec",   req_vec, m_snap);
    chk("pending",   pending, m_pend);
    chk("overflow",  {7'b0, overflow}, {7'b0, m_ovf});
  endtask

  task automatic do_reset();
    rst = 1'b1; irq_in = 8'h00; req_ready = 1'b0; done = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq_in = 8'h00; irq_mask = 8'hFF;
    req_ready = 1'b0; done = 1'b0; done_idx = 3'd0;

    // Reset, then idle with no requests.
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("idle_valid", {7'b0, req_valid}, 8'h00);
    chk("idle_vec", req_vec, 8'h00);
    chk("idle_pending", pending, 8'h00);
    chk("idle_ovf", {7'b0, overflow}, 8'h00);

    // Single request on line 5.
    irq_in = 8'h20;
    step();
    chk("single_pending", pending, 8'h20);
    chk("single_valid_early", {7'b0, req_valid}, 8'h00);
    step();
    chk("single_valid", {7'b0, req_valid}, 8'h01);
    chk("single_vec", req_vec, 8'h20);
    req_ready = 1'b1;
    step();
    chk("single_busy_valid", {7'b0, req_valid}, 8'h00);
    req_ready = 1'b0; done = 1'b1; done_idx = 3'd5; irq_in = 8'h00;
    step();
    done = 1'b0;
    chk("single_cleared", pending, 8'h00);
    step();
    chk("single_no_reoffer", {7'b0, req_valid}, 8'h00);

    // Snapshot freeze while offered and serviced.
    do_reset();
    irq_in = 8'h42;
    step();
    step();
    chk("freeze_vec", req_vec, 8'h42);
    irq_in = 8'hC2; irq_mask = 8'h0F;
    step();
    chk("freeze_hold_vec", req_vec, 8'h42);
    chk("freeze_pending", pending, 8'hC2);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    chk("freeze_busy_vec", req_vec, 8'h42);
    done = 1'b1; done_idx = 3'd6; irq_mask = 8'hFF;
    step();
    done = 1'b0;
    chk("freeze_after_done_pending", pending, 8'h82);
    step();
    chk("freeze_reoffer_valid", {7'b0, req_valid}, 8'h01);
    chk("freeze_reoffer_vec", req_vec, 8'h82);

    // Masked pending bits stay pending until unmasked.
    do_reset();
    irq_mask = 8'h00; irq_in = 8'h0C;
    step();
    irq_in = 8'h00;
    for (int i = 0; i < 20; i++) step();
    chk("mask_no_valid", {7'b0, req_valid}, 8'h00);
    chk("mask_pending", pending, 8'h0C);
    irq_mask = 8'h04;
    step();
    step();
    chk("mask_valid", {7'b0, req_valid}, 8'h01);
    chk("mask_vec", req_vec, 8'h04);

    // Set/clear collision keeps the new event; re-edge while pending overflows.
    do_reset();
    irq_mask = 8'hFF; irq_in = 8'h08;
    step();
    irq_in = 8'h00;
    step();
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    irq_in = 8'h08; done = 1'b1; done_idx = 3'd3;
    step();
    done = 1'b0;
    chk("collide_pending", pending, 8'h08);
    chk("collide_ovf", {7'b0, overflow}, 8'h00);
    irq_in = 8'h00;
    step();
    irq_in = 8'h08;
    step();
    chk("ovf_set", {7'b0, overflow}, 8'h01);
    irq_in = 8'h00;
    for (int i = 0; i < 4; i++) step();
    chk("ovf_sticky", {7'b0, overflow}, 8'h01);

    // Reset while offering; a line high across reset release is a new edge.
    do_reset();
    irq_in = 8'h10;
    step();
    irq_in = 8'h00;
    step();
    chk("midrst_vec", req_vec, 8'h10);
    rst = 1'b1; irq_in = 8'h01;
    step();
    chk("midrst_valid", {7'b0, req_valid}, 8'h00);
    chk("midrst_pending", pending, 8'h00);
    rst = 1'b0;
    step();
    chk("midrst_capture", pending, 8'h01);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(63, 0) == 0);
      irq_in    = 8'($urandom) & 8'($urandom);
      irq_mask  = 8'($urandom) | 8'($urandom);
      req_ready = ($urandom_range(1, 0) == 1);
      done      = ($urandom_range(2, 0) == 0);
      done_idx  = 3'($urandom_range(7, 0));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
